// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and gates N_SRC request lines onto HWInt.
// Register window: PEND (W1C), MASK, MODE (1 = edge), CTRL (GEN, irq_id, irq_any).
module irq_ctrl #(
  parameter int unsigned N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] HWInt,
  output logic [2:0]       irq_id,
  output logic             irq_any
);

  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
  logic             gen_q, gen_d;

  logic       hit;
  logic       wr;
  logic [1:0] sel;

  assign hit = (Addr[31:4] == BASE_ADDR[31:4]);
  assign sel = Addr[3:2];
  assign wr  = hit & WE;

  always_comb begin
    pend_d     = pend_q;
    mask_d     = mask_q;
    mode_d     = mode_q;
    gen_d      = gen_q;
    irq_prev_d = irq_in;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (mode_q[i]) begin
        // Edge mode: a new edge wins over a same-cycle W1C.
        if (irq_in[i] && !irq_prev_q[i]) begin
          pend_d[i] = 1'b1;
        end else if (wr && (sel == 2'd0) && Din[i]) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = irq_in[i];
      end
    end
    if (wr) begin
      unique case (sel)
        2'd1:    mask_d = Din[N_SRC-1:0];
        2'd2:    mode_d = Din[N_SRC-1:0];
        2'd3:    gen_d  = Din[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      irq_prev_q <= '0;
      gen_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      irq_prev_q <= irq_prev_d;
      gen_q      <= gen_d;
    end
  end

  assign HWInt   = pend_q & mask_q & {N_SRC{gen_q}};
  assign irq_any = |HWInt;

  // Descending scan so the lowest-numbered active source is the last (winning) write.
  always_comb begin
    irq_id = 3'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (HWInt[i]) begin
        irq_id = 3'(i);
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    if (hit) begin
      unique case (sel)
        2'd0:    Dout = {{(32 - N_SRC){1'b0}}, pend_q};
        2'd1:    Dout = {{(32 - N_SRC){1'b0}}, mask_q};
        2'd2:    Dout = {{(32 - N_SRC){1'b0}}, mode_q};
        default: Dout = {15'd0, irq_any, 5'd0, irq_id, 7'd0, gen_q};
      endcase
    end
  end

endmodule
